// File: rtl/ps2_command_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device command transmitter. It inhibits the clock, issues a request-to-send,
// shifts bits out on device clock falls and checks the ACK. Lines are only pulled low or released.
//
// state        | meaning
// S_IDLE       | bus released, waiting for send_command
// S_INHIBIT    | clock held low, data released
// S_RTS        | clock and data low (start bit), one cycle
// S_WAIT_FIRST | clock released, data low, waiting for first device fall
// S_DATA       | data bits, parity, then stop presented on successive falls
// S_ACK        | data released, device ACK sampled on next fall
// S_WAIT_IDLE  | waiting for both lines high before reporting success
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] the_command,
  input  logic       send_command,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out,
  output logic       error_no_ack
);
  localparam int TMAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int TMAX   = (TMAX_A > XFER_TIMEOUT) ? TMAX_A : XFER_TIMEOUT;
  localparam int TW     = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_WAIT_FIRST, S_DATA, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t          r_state, w_state_next;
  logic            r_clk_s1, r_clk_s2, r_clk_prev;
  logic            r_dat_s1, r_dat_s2;
  logic [8:0]      r_shift;
  logic [3:0]      r_bitcnt;
  logic [TW-1:0]   r_timer;
  logic            r_dat_low;
  logic            r_done, r_tmo, r_nack;

  logic            w_fall;
  logic            w_accept, w_bit_step;
  logic            w_timer_load, w_timer_dec;
  logic [TW-1:0]   w_timer_val;
  logic            w_done, w_tmo, w_nack;
  logic            w_clk_low, w_dat_low;

  assign w_fall = r_clk_prev & ~r_clk_s2;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_bit_step   = 1'b0;
    w_timer_load = 1'b0;
    w_timer_dec  = 1'b0;
    w_timer_val  = '0;
    w_done       = 1'b0;
    w_tmo        = 1'b0;
    w_nack       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (send_command) begin
          w_accept     = 1'b1;
          w_timer_load = 1'b1;
          w_timer_val  = TW'(INHIBIT_CYCLES - 1);
          w_state_next = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_timer == '0) w_state_next = S_RTS;
        else               w_timer_dec  = 1'b1;
      end
      S_RTS: begin
        w_timer_load = 1'b1;
        w_timer_val  = TW'(START_TIMEOUT - 1);
        w_state_next = S_WAIT_FIRST;
      end
      S_WAIT_FIRST: begin
        if (w_fall) begin
          w_bit_step   = 1'b1;
          w_timer_load = 1'b1;
          w_timer_val  = TW'(XFER_TIMEOUT - 1);
          w_state_next = S_DATA;
        end else if (r_timer == '0) begin
          w_tmo        = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_timer_dec  = 1'b1;
        end
      end
      S_DATA: begin
        w_timer_dec = 1'b1;
        if (w_fall) begin
          w_bit_step = 1'b1;
          if (r_bitcnt == 4'd9) w_state_next = S_ACK;
        end else if (r_timer == '0) begin
          w_tmo        = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_ACK: begin
        w_timer_dec = 1'b1;
        // ACK edge takes priority over a coincident timeout
        if (w_fall) begin
          if (r_dat_s2) begin
            w_nack       = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_WAIT_IDLE;
          end
        end else if (r_timer == '0) begin
          w_tmo        = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        w_timer_dec = 1'b1;
        if (r_clk_s2 && r_dat_s2) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_timer == '0) begin
          w_tmo        = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_timer    <= '0;
      r_dat_low  <= 1'b0;
      r_done     <= 1'b0;
      r_tmo      <= 1'b0;
      r_nack     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_clk_s1   <= PS2_CLK;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= PS2_DAT;
      r_dat_s2   <= r_dat_s1;
      r_done     <= w_done;
      r_tmo      <= w_tmo;
      r_nack     <= w_nack;

      if (w_timer_load)                     r_timer <= w_timer_val;
      else if (w_timer_dec && r_timer != '0) r_timer <= r_timer - 1'b1;

      // Ones shift in behind the data so the tenth presented bit is the released stop bit
      if (w_accept) begin
        r_shift   <= {~^the_command, the_command};
        r_bitcnt  <= '0;
        r_dat_low <= 1'b0;
      end else if (w_bit_step) begin
        r_dat_low <= ~r_shift[0];
        r_shift   <= {1'b1, r_shift[8:1]};
        r_bitcnt  <= r_bitcnt + 1'b1;
      end
    end
  end

  assign w_clk_low = (r_state == S_INHIBIT) || (r_state == S_RTS);
  assign w_dat_low = (r_state == S_RTS) || (r_state == S_WAIT_FIRST) ||
                     ((r_state == S_DATA) && r_dat_low);

  assign PS2_CLK = w_clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = w_dat_low ? 1'b0 : 1'bz;

  assign busy                          = (r_state != S_IDLE);
  assign command_was_sent              = r_done;
  assign error_communication_timed_out = r_tmo;
  assign error_no_ack                  = r_nack;

endmodule

// File: tb/tb_ps2_command_tx.sv
`timescale 1ns/1ps
// Directed bench for ps2_command_tx with a simple PS/2 device model clocking at 1/40 of CLOCK_50.
module tb_ps2_command_tx;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] the_command = 8'h00;
  logic       send_command = 1'b0;
  wire        ps2_clk;
  wire        ps2_dat;
  logic       busy, command_was_sent, error_communication_timed_out, error_no_ack;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  int   dev_falls = 0;

  int checks = 0;
  int errors = 0;
  int n_done = 0, n_tmo = 0, n_nack = 0, n_pulse_busy = 0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_command_tx #(
    .INHIBIT_CYCLES(10),
    .START_TIMEOUT (200),
    .XFER_TIMEOUT  (2000)
  ) dut (
    .CLOCK_50                     (clk),
    .reset                        (reset),
    .the_command                  (the_command),
    .send_command                 (send_command),
    .PS2_CLK                      (ps2_clk),
    .PS2_DAT                      (ps2_dat),
    .busy                         (busy),
    .command_was_sent             (command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .error_no_ack                 (error_no_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (command_was_sent) n_done++;
    if (error_communication_timed_out) n_tmo++;
    if (error_no_ack) n_nack++;
    if ((command_was_sent || error_communication_timed_out || error_no_ack) && busy) n_pulse_busy++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic dev_clock(input int n_falls, input bit ack_low, output logic [10:0] bits);
    bits = '1;
    dev_falls = 0;
    for (int k = 0; k < n_falls; k++) begin
      repeat (10) @(negedge clk);
      if (k == 10 && ack_low) dev_dat_low = 1'b1;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b1;
      dev_falls = k + 1;
      repeat (19) @(negedge clk);
      bits[k] = ps2_dat;
      @(negedge clk);
      dev_clk_low = 1'b0;
    end
    repeat (10) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic start_cmd(input logic [7:0] cmd, output bit ok);
    the_command = cmd;
    send_command = 1'b1;
    @(negedge clk);
    send_command = 1'b0;
    the_command = 8'h00;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ps2_clk === 1'b1 && ps2_dat === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({command_was_sent, error_communication_timed_out, error_no_ack} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b want 000", {command_was_sent, error_communication_timed_out, error_no_ack}); end
    checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL reset_clk_released got %b want 1", ps2_clk); end
    checks++; if (ps2_dat !== 1'b1) begin errors++; $display("FAIL reset_dat_released got %b want 1", ps2_dat); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send_ed();
    int n_inh;
    int d0, t0, k0, p0;
    logic [10:0] bits;
    d0 = n_done; t0 = n_tmo; k0 = n_nack; p0 = n_pulse_busy;
    the_command = 8'hED;
    send_command = 1'b1;
    @(negedge clk);
    send_command = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ed_busy_on_accept got %b want 1", busy); end
    n_inh = 0;
    while (n_inh < 50 && ps2_clk === 1'b0 && ps2_dat === 1'b1) begin
      n_inh++;
      @(negedge clk);
    end
    checks++; if (n_inh != 10) begin errors++; $display("FAIL ed_inhibit_cycles got %0d want 10", n_inh); end
    checks++; if ({ps2_clk, ps2_dat} !== 2'b00) begin errors++; $display("FAIL ed_rts got %b want 00", {ps2_clk, ps2_dat}); end
    @(negedge clk);
    checks++; if ({ps2_clk, ps2_dat} !== 2'b10) begin errors++; $display("FAIL ed_clk_release got %b want 10", {ps2_clk, ps2_dat}); end
    dev_clock(11, 1'b1, bits);
    checks++; if (bits[8:0] !== 9'h1ED) begin errors++; $display("FAIL ed_bits got %h want 1ed", bits[8:0]); end
    checks++; if (bits[9] !== 1'b1) begin errors++; $display("FAIL ed_stop_released got %b want 1", bits[9]); end
    wait_not_busy();
    repeat (2) @(negedge clk);
    checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL ed_done_pulse got %0d want 1", n_done - d0); end
    checks++; if ((n_tmo - t0) + (n_nack - k0) != 0) begin errors++; $display("FAIL ed_no_error got %0d want 0", (n_tmo - t0) + (n_nack - k0)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ed_busy_end got %b want 0", busy); end
    checks++; if (n_pulse_busy != p0) begin errors++; $display("FAIL ed_busy_with_pulse got %0d want %0d", n_pulse_busy, p0); end
  endtask

  task automatic test_send_f4();
    int d0;
    bit ok;
    logic [10:0] bits;
    d0 = n_done;
    start_cmd(8'hF4, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL f4_rts_seen got %b want 1", ok); end
    dev_clock(11, 1'b1, bits);
    checks++; if (bits[9:0] !== 10'h2F4) begin errors++; $display("FAIL f4_bits got %h want 2f4", bits[9:0]); end
    wait_not_busy();
    repeat (2) @(negedge clk);
    checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL f4_done_pulse got %0d want 1", n_done - d0); end
  endtask

  task automatic test_no_clock();
    int t0, d0, cnt;
    bit ok;
    t0 = n_tmo; d0 = n_done;
    start_cmd(8'hFF, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL noclk_rts_seen got %b want 1", ok); end
    cnt = 0;
    while (n_tmo == t0 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    checks++; if (cnt < 199 || cnt > 201) begin errors++; $display("FAIL noclk_timeout_cycles got %0d want 200", cnt); end
    checks++; if ({busy, ps2_clk, ps2_dat} !== 3'b011) begin errors++; $display("FAIL noclk_released got %b want 011", {busy, ps2_clk, ps2_dat}); end
    repeat (5) @(negedge clk);
    checks++; if (n_tmo - t0 != 1 || n_done != d0) begin errors++; $display("FAIL noclk_pulses got tmo %0d done %0d want 1 0", n_tmo - t0, n_done - d0); end
  endtask

  task automatic test_no_ack();
    int d0, k0;
    bit ok;
    logic [10:0] bits;
    d0 = n_done; k0 = n_nack;
    start_cmd(8'hF4, ok);
    dev_clock(11, 1'b0, bits);
    wait_not_busy();
    repeat (2) @(negedge clk);
    checks++; if (n_nack - k0 != 1) begin errors++; $display("FAIL noack_pulse got %0d want 1", n_nack - k0); end
    checks++; if (n_done != d0) begin errors++; $display("FAIL noack_no_done got %0d want 0", n_done - d0); end
    checks++; if ({busy, ps2_clk, ps2_dat} !== 3'b011) begin errors++; $display("FAIL noack_released got %b want 011", {busy, ps2_clk, ps2_dat}); end
  endtask

  task automatic test_xfer_timeout();
    int t0, d0, cnt;
    bit ok;
    logic [10:0] bits;
    t0 = n_tmo; d0 = n_done;
    start_cmd(8'hED, ok);
    dev_clock(5, 1'b0, bits);
    cnt = 0;
    while (n_tmo == t0 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    checks++; if (cnt < 1780 || cnt > 1860) begin errors++; $display("FAIL xfer_timeout_cycles got %0d want about 1813", cnt); end
    checks++; if ({busy, ps2_clk, ps2_dat} !== 3'b011) begin errors++; $display("FAIL xfer_released got %b want 011", {busy, ps2_clk, ps2_dat}); end
    checks++; if (n_tmo - t0 != 1 || n_done != d0) begin errors++; $display("FAIL xfer_pulses got tmo %0d done %0d want 1 0", n_tmo - t0, n_done - d0); end
  endtask

  task automatic test_back_to_back();
    int d0;
    bit ok;
    logic [10:0] bits;
    d0 = n_done;
    start_cmd(8'hED, ok);
    fork
      dev_clock(11, 1'b1, bits);
      begin
        repeat (100) @(negedge clk);
        the_command = 8'h00;
        send_command = 1'b1;
        @(negedge clk);
        send_command = 1'b0;
      end
    join
    wait_not_busy();
    checks++; if (bits[8:0] !== 9'h1ED) begin errors++; $display("FAIL b2b_bits got %h want 1ed", bits[8:0]); end
    repeat (30) @(negedge clk);
    checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL b2b_done got %0d want 1", n_done - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_not_queued got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int d0, t0, k0;
    bit ok, seen;
    logic [10:0] bits;
    d0 = n_done; t0 = n_tmo; k0 = n_nack;
    start_cmd(8'hF4, ok);
    fork
      dev_clock(11, 1'b0, bits);
      begin
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
          if (dev_falls == 4) begin
            seen = 1'b1;
            break;
          end
          @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstmid_fall4_seen got %b want 1", seen); end
        checks++; if ({busy, ps2_dat} !== 2'b01) begin errors++; $display("FAIL rstmid_released got %b want 01", {busy, ps2_dat}); end
      end
    join
    repeat (20) @(negedge clk);
    checks++; if ((n_done - d0) + (n_tmo - t0) + (n_nack - k0) != 0) begin
      errors++; $display("FAIL rstmid_no_pulses got %0d want 0", (n_done - d0) + (n_tmo - t0) + (n_nack - k0)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    start_cmd(8'hED, ok);
    dev_clock(11, 1'b1, bits);
    wait_not_busy();
    repeat (2) @(negedge clk);
    checks++; if (bits[8:0] !== 9'h1ED) begin errors++; $display("FAIL rstmid_resend_bits got %h want 1ed", bits[8:0]); end
    checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL rstmid_resend_done got %0d want 1", n_done - d0); end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_send_f4();
    test_no_clock();
    test_no_ack();
    test_xfer_timeout();
    test_back_to_back();
    test_reset_mid();
    checks++; if (n_pulse_busy != 0) begin errors++; $display("FAIL pulse_with_busy got %0d want 0", n_pulse_busy); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
